// File: rtl/sel_skid_mux_pkg.sv
// rtl/sel_skid_mux_pkg.sv - shared state enum, default sizes and select-width helper for sel_skid_mux
package sel_skid_mux_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_N     = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sel_skid_mux_if.sv
// rtl/sel_skid_mux_if.sv - handshake bundle for sel_skid_mux; sel_err exists only with SEL_SKID_MUX_SEL_ERR_EN
interface sel_skid_mux_if
    import sel_skid_mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N
) ();
    localparam int SELW = sel_width(N);

    logic                 in_valid;
    logic                 in_ready;
    logic [N*WIDTH-1:0]   in_data;
    logic [SELW-1:0]      in_sel;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
`ifdef SEL_SKID_MUX_SEL_ERR_EN
    logic                 sel_err;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, sel_err
    );
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, sel_err
    );
`else
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );
`endif

endinterface

// File: rtl/sel_skid_mux_mux_n.sv
// rtl/sel_skid_mux_mux_n.sv - N-way combinational channel selector; out-of-range select yields channel 0
module mux_n
    import sel_skid_mux_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int N     = DEF_N,
    localparam int SELW  = sel_width(N)
) (
    input  logic [N*WIDTH-1:0] data_i,
    input  logic [SELW-1:0]    sel_i,
    output logic [WIDTH-1:0]   data_o
);

    always_comb begin
        data_o = data_i[WIDTH-1:0];
        for (int k = 1; k < N; k++) begin
            if (sel_i == SELW'(k)) begin
                data_o = data_i[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/sel_skid_mux.sv
// rtl/sel_skid_mux.sv - registered channel select with 2-entry skid; SEL_SKID_MUX_SEL_ERR_EN adds sel_err pulse
module sel_skid_mux
    import sel_skid_mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    sel_skid_mux_if.slave bus
);

    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_q;
    logic             out_valid_q;
    state_e           state_q;
    logic             in_xfer;
    logic             out_xfer;

    mux_n #(
        .WIDTH (WIDTH),
        .N     (N)
    ) u_mux (
        .data_i (bus.in_data),
        .sel_i  (bus.in_sel),
        .data_o (sel_data)
    );

    assign in_xfer       = bus.in_valid && in_ready_q;
    assign out_xfer      = out_valid_q && bus.out_ready;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

`ifdef SEL_SKID_MUX_SEL_ERR_EN
    localparam int SELW = sel_width(N);
    localparam logic [SELW:0] N_LIM = (SELW+1)'(N);

    logic sel_err_q;
    logic sel_oor;

    assign sel_oor     = {1'b0, bus.in_sel} >= N_LIM;
    assign bus.sel_err = sel_err_q;
`endif

    // in_ready/out_valid are recomputed with every state move so both stay pure flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            out_data_q  <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SEL_SKID_MUX_SEL_ERR_EN
            sel_err_q   <= 1'b0;
`endif
        end else if (flush) begin
            state_q     <= EMPTY;
            out_data_q  <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SEL_SKID_MUX_SEL_ERR_EN
            sel_err_q   <= 1'b0;
`endif
        end else begin
`ifdef SEL_SKID_MUX_SEL_ERR_EN
            sel_err_q <= in_xfer && sel_oor;
`endif
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        out_data_q  <= sel_data;
                        state_q     <= ONE;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        out_data_q <= sel_data;
                    end else if (in_xfer) begin
                        skid_q     <= sel_data;
                        state_q    <= TWO;
                        in_ready_q <= 1'b0;
                    end else if (out_xfer) begin
                        state_q     <= EMPTY;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        out_data_q <= skid_q;
                        state_q    <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sel_skid_mux.sv
// tb/tb_sel_skid_mux.sv - randomized bench for sel_skid_mux against a 2-deep queue reference model
module tb_sel_skid_mux;
    import sel_skid_mux_pkg::*;

    localparam int W = 32;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic flush  = 1'b0;
    logic flush3 = 1'b0;

    always #5 clk = ~clk;

    sel_skid_mux_if #(.WIDTH(W), .N(4)) bus4 ();
    sel_skid_mux_if #(.WIDTH(W), .N(3)) bus3 ();

    sel_skid_mux #(.WIDTH(W), .N(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus4)
    );

    sel_skid_mux #(.WIDTH(W), .N(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush3),
        .bus   (bus3)
    );

    int n_chk = 0;
    int n_bad = 0;

    logic [W-1:0] q[$];
    logic [W-1:0] rx[$];
    bit           zero_known = 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pick(input logic [4*W-1:0] d, input int s, input int n);
        int idx;
        idx = (s < n) ? s : 0;
        return W'(d >> (W * idx));
    endfunction

    task automatic check_outs(input string ph);
        chk({ph, ":in_ready"}, 64'(bus4.in_ready), 64'(q.size() < 2));
        chk({ph, ":out_valid"}, 64'(bus4.out_valid), 64'(q.size() > 0));
        if (q.size() > 0)
            chk({ph, ":out_data"}, 64'(bus4.out_data), 64'(q[0]));
        else if (zero_known)
            chk({ph, ":out_data_zero"}, 64'(bus4.out_data), 64'd0);
`ifdef SEL_SKID_MUX_SEL_ERR_EN
        chk({ph, ":sel_err"}, 64'(bus4.sel_err), 64'd0);
`endif
    endtask

    // Drive one cycle after a falling edge, advance the model on the rising edge, check on the next falling edge.
    task automatic cycle(input logic v, input logic [1:0] s, input logic [4*W-1:0] d,
                         input logic ordy, input logic fl, output logic acc);
        logic in_x, out_x;
        bus4.in_valid  = v;
        bus4.in_sel    = s;
        bus4.in_data   = d;
        bus4.out_ready = ordy;
        flush          = fl;
        in_x  = v && (q.size() < 2) && !fl;
        out_x = (q.size() > 0) && ordy && !fl;
        if (out_x) rx.push_back(bus4.out_data);
        @(posedge clk);
        if (fl) begin
            q.delete();
            zero_known = 1'b1;
        end else begin
            if (out_x) void'(q.pop_front());
            if (in_x) begin
                q.push_back(pick(d, int'(s), 4));
                zero_known = 1'b0;
            end
        end
        @(negedge clk);
        acc = in_x;
        check_outs("cyc");
    endtask

    function automatic logic [4*W-1:0] one_word(input int ch, input logic [W-1:0] val);
        logic [4*W-1:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        d[ch*W +: W] = val;
        return d;
    endfunction

    initial begin
        logic           acc;
        logic [4*W-1:0] d;
        logic [3*W-1:0] d3;
        int             val;
        int             cycles;
        int             ch;

        bus4.in_valid = 1'b0; bus4.in_sel = '0; bus4.in_data = '0; bus4.out_ready = 1'b0;
        bus3.in_valid = 1'b0; bus3.in_sel = '0; bus3.in_data = '0; bus3.out_ready = 1'b0;

        #12;
        chk("rst:in_ready", 64'(bus4.in_ready), 64'd1);
        chk("rst:out_valid", 64'(bus4.out_valid), 64'd0);
        chk("rst:out_data", 64'(bus4.out_data), 64'd0);
        chk("rst3:in_ready", 64'(bus3.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        check_outs("post_rst");

        d = one_word(2, 32'hDEADBEEF);
        cycle(1'b1, 2'd2, d, 1'b1, 1'b0, acc);
        chk("t030:out_valid", 64'(bus4.out_valid), 64'd1);
        chk("t030:out_data", 64'(bus4.out_data), 64'hDEADBEEF);
        cycle(1'b0, 2'd0, '0, 1'b1, 1'b0, acc);

        cycle(1'b1, 2'd0, one_word(0, 32'h11), 1'b0, 1'b0, acc);
        cycle(1'b1, 2'd1, one_word(1, 32'h22), 1'b0, 1'b0, acc);
        chk("t031:in_ready_two", 64'(bus4.in_ready), 64'd0);
        cycle(1'b1, 2'd3, one_word(3, 32'h33), 1'b0, 1'b0, acc);
        chk("t031:still_blocked", 64'(bus4.in_ready), 64'd0);
        chk("t031:head_kept", 64'(bus4.out_data), 64'h11);
        rx.delete();
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, '0, 1'b1, 1'b0, acc);
        chk("t031:rx_count", 64'(rx.size()), 64'd2);
        chk("t031:rx0", 64'((rx.size() > 0) ? rx[0] : '1), 64'h11);
        chk("t031:rx1", 64'((rx.size() > 1) ? rx[1] : '1), 64'h22);

        cycle(1'b1, 2'd0, one_word(0, 32'h44), 1'b0, 1'b0, acc);
        cycle(1'b1, 2'd0, one_word(0, 32'h55), 1'b0, 1'b0, acc);
        cycle(1'b1, 2'd0, one_word(0, 32'h66), 1'b1, 1'b1, acc);
        chk("t033:out_valid", 64'(bus4.out_valid), 64'd0);
        chk("t033:in_ready", 64'(bus4.in_ready), 64'd1);
        chk("t033:out_data", 64'(bus4.out_data), 64'd0);

        rx.delete();
        val = 1;
        cycles = 0;
        while ((val <= 100 || q.size() > 0) && cycles < 3000) begin
            ch = int'($urandom_range(0, 3));
            cycle(val <= 100, 2'(ch), one_word(ch, 32'(val)), 1'($urandom_range(0, 1)), 1'b0, acc);
            if (acc) val++;
            cycles++;
        end
        chk("t032:finished", 64'(cycles < 3000), 64'd1);
        chk("t032:rx_count", 64'(rx.size()), 64'd100);
        for (int i = 0; i < 100; i++)
            chk("t032:order", 64'((i < rx.size()) ? rx[i] : '1), 64'(i + 1));

        for (int i = 0; i < 400; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            cycle(($urandom % 4) != 0, 2'($urandom), d, ($urandom % 3) != 0,
                  ($urandom % 40) == 0, acc);
        end

        cycle(1'b0, 2'd0, '0, 1'b1, 1'b0, acc);
        cycle(1'b0, 2'd0, '0, 1'b1, 1'b0, acc);
        cycle(1'b1, 2'd0, one_word(0, 32'h77), 1'b0, 1'b0, acc);
        cycle(1'b1, 2'd0, one_word(0, 32'h88), 1'b0, 1'b0, acc);
        chk("t035:in_two", 64'(bus4.in_ready), 64'd0);
        bus4.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t035:out_valid", 64'(bus4.out_valid), 64'd0);
        chk("t035:in_ready", 64'(bus4.in_ready), 64'd1);
        chk("t035:out_data", 64'(bus4.out_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        zero_known = 1'b1;
        check_outs("t026_idle");
        cycle(1'b1, 2'd1, one_word(1, 32'hCAFE), 1'b1, 1'b0, acc);
        chk("t026:out_valid", 64'(bus4.out_valid), 64'd1);
        chk("t026:out_data", 64'(bus4.out_data), 64'hCAFE);
        cycle(1'b0, 2'd0, '0, 1'b1, 1'b0, acc);

        bus3.out_ready = 1'b1;
        bus3.in_valid  = 1'b1;
        bus3.in_sel    = 2'd3;
        d3 = {32'h333, 32'h222, 32'hA5};
        bus3.in_data   = d3;
        @(posedge clk);
        @(negedge clk);
        bus3.in_valid = 1'b0;
        chk("t034:out_valid", 64'(bus3.out_valid), 64'd1);
        chk("t034:out_data", 64'(bus3.out_data), 64'hA5);
`ifdef SEL_SKID_MUX_SEL_ERR_EN
        chk("t034:sel_err_hi", 64'(bus3.sel_err), 64'd1);
`endif
        @(posedge clk);
        @(negedge clk);
        chk("t034:drained", 64'(bus3.out_valid), 64'd0);
`ifdef SEL_SKID_MUX_SEL_ERR_EN
        chk("t034:sel_err_lo", 64'(bus3.sel_err), 64'd0);
`endif
        bus3.in_valid = 1'b1;
        bus3.in_sel   = 2'd1;
        d3 = {32'h333, 32'h5A, 32'hA5};
        bus3.in_data  = d3;
        @(posedge clk);
        @(negedge clk);
        bus3.in_valid = 1'b0;
        chk("t034:ch1_data", 64'(bus3.out_data), 64'h5A);
`ifdef SEL_SKID_MUX_SEL_ERR_EN
        chk("t034:ch1_no_err", 64'(bus3.sel_err), 64'd0);
        bus3.in_valid = 1'b1;
        bus3.in_sel   = 2'd3;
        flush3        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus3.in_valid = 1'b0;
        flush3        = 1'b0;
        chk("t034:flush_no_err", 64'(bus3.sel_err), 64'd0);
        chk("t034:flush_empty", 64'(bus3.out_valid), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/sel_skid_mux.md
SEL_SKID_MUX -- requirements
Module: sel_skid_mux

Interface
REQ-001 Parameter WIDTH, default 32, bit width of each data channel (>=1).
REQ-002 Parameter N, default 4, number of input channels (>=2); SELW = max(1, clog2(N)).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  synchronous clear of all buffered data (pipeline squash).
REQ-006 in_valid  input  1  upstream word valid.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 in_data  input  N*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 in_sel  input  SELW  binary channel select, sampled with the word.
REQ-010 out_valid  output  1  output register holds a word.
REQ-011 out_ready  input  1  downstream accepts the word.
REQ-012 out_data  output  WIDTH  selected, registered channel data.
REQ-013 sel_err  output  1  out-of-range select flag (present only per REQ-027).

Function
REQ-014 A transfer in SHALL occur when in_valid && in_ready; a transfer out SHALL occur when out_valid && out_ready.
REQ-015 The accepted word SHALL be in_data channel in_sel; if in_sel >= N, channel 0 SHALL be taken.
REQ-016 Latency SHALL be exactly 1 cycle from input transfer to out_valid when the block is empty; throughput SHALL be 1 word/cycle with out_ready held high.
REQ-017 State machine SHALL have EMPTY (no word), ONE (output register full), TWO (output and skid register full).
REQ-018 EMPTY: input transfer -> ONE; otherwise stay.
REQ-019 ONE: input and output transfer together -> ONE with new word in output register; input only -> TWO, word into skid; output only -> EMPTY.
REQ-020 TWO: output transfer -> ONE, skid word moves to output register; otherwise stay.
REQ-021 in_ready SHALL be a registered function of state: 1 in EMPTY and ONE, 0 in TWO; it SHALL NOT depend combinationally on out_ready.
REQ-022 out_data and out_valid SHALL come directly from registers; out_data SHALL stay stable while out_valid && !out_ready.
REQ-023 Word order SHALL be preserved; no word SHALL be lost or duplicated.
REQ-024 flush SHALL take priority over all transfers: next state EMPTY, in_valid ignored that cycle, both data registers cleared to 0.

Reset
REQ-025 While rst_n is low: state EMPTY, out_valid 0, out_data 0, skid data 0, in_ready 1, sel_err 0, all independent of clk.
REQ-026 Deassertion of rst_n mid-transfer SHALL discard all in-flight words; first accept is possible on the first rising edge after deassertion.

Configuration
REQ-027 Macro SEL_SKID_MUX_SEL_ERR_EN defined: sel_err SHALL be a registered 1-cycle pulse following any input transfer with in_sel >= N; cleared by flush and reset. Undefined: sel_err port absent, no error logic; data behaviour identical.

Structure
REQ-028 A shared package SHALL hold the state enum (EMPTY, ONE, TWO) and the default WIDTH/N constants.
REQ-029 The N-way combinational selector SHALL be a sub-module, mux_n (parameters WIDTH, N), generalising the existing 2:1 select.

Verification
REQ-030 N=4, WIDTH=32, out_ready=1, push sel=2 with ch2=0xDEADBEEF -> out_valid=1, out_data=0xDEADBEEF next cycle.
REQ-031 out_ready=0, push 0x11 then 0x22 -> state TWO, in_ready=0, 0x33 not accepted; raise out_ready -> 0x11, 0x22 emitted in order.
REQ-032 Continuous stream 1..100 with random out_ready -> output sequence 1..100 exactly, no gaps or repeats.
REQ-033 Block in TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, out_data=0.
REQ-034 N=3, push sel=3 with ch0=0xA5 -> out_data=0xA5; with SEL_SKID_MUX_SEL_ERR_EN, sel_err=1 for exactly one cycle.
REQ-035 Assert rst_n=0 asynchronously while in TWO -> out_valid=0 and in_ready=1 immediately, before the next clock edge.
